// File: rtl/seq_slice_adder_if.sv
// Handshake and data bundle for seq_slice_adder.
// The slave modport is the adder's view; the master modport is the producer/consumer view.
interface seq_slice_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output z,
        output cout,
        output ovf
    );

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  z,
        input  cout,
        input  ovf
    );
endinterface

// File: rtl/seq_slice_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that processes SLICE bits per clock,
// LSB slice first, with a registered carry between slices. One operation is in
// flight at a time: IDLE accepts operands, RUN walks the slices, DONE holds the
// result until the consumer takes it. The interface instance must be built with
// the same WIDTH as this module.
module seq_slice_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    seq_slice_adder_if.slave   bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // Slice width must tile the operand exactly, otherwise the top slice would be ragged.
    generate
        if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : gBadSlice
            $error("seq_slice_adder: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     count_q;
    logic [WIDTH-1:0]  aOpnd_q;
    logic [WIDTH-1:0]  bEff_q;
    logic              carry_q;
    logic [WIDTH-1:0]  z_q;
    logic              cout_q;
    logic              ovf_q;
    logic              outValid_q;

    logic [SLICE-1:0]  aSlice;
    logic [SLICE-1:0]  bSlice;
    logic [SLICE:0]    sliceSum_d;
    logic              topCarry_d;
    logic [WIDTH-1:0]  aOpnd_d;
    logic [WIDTH-1:0]  bEff_d;
    logic              lastSlice;

    assign aSlice    = aOpnd_q[SLICE-1:0];
    assign bSlice    = bEff_q[SLICE-1:0];
    assign lastSlice = (count_q == CW'(NSLICE - 1));

    // Add the current low slice of both operands plus the carry held from the previous slice.
    always_comb begin
        sliceSum_d = {1'b0, aSlice} + {1'b0, bSlice} + {{SLICE{1'b0}}, carry_q};
        topCarry_d = aSlice[SLICE-1] ^ bSlice[SLICE-1] ^ sliceSum_d[SLICE-1];
    end

    // The A register doubles as the accumulator: the consumed slice shifts out at
    // the bottom while the fresh sum shifts in at the top, so after NSLICE steps it
    // holds the full result in order. B just shifts its next slice down.
    generate
        if (SLICE < WIDTH) begin : gMultiSlice
            assign aOpnd_d = {sliceSum_d[SLICE-1:0], aOpnd_q[WIDTH-1:SLICE]};
            assign bEff_d  = {{SLICE{1'b0}}, bEff_q[WIDTH-1:SLICE]};
        end else begin : gSingleSlice
            assign aOpnd_d = sliceSum_d[SLICE-1:0];
            assign bEff_d  = bEff_q;
        end
    endgenerate

    // Control FSM with registered results; z/cout/ovf only move on the final slice edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            aOpnd_q    <= '0;
            bEff_q     <= '0;
            carry_q    <= 1'b0;
            z_q        <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        aOpnd_q <= bus.a;
                        bEff_q  <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.cin ^ bus.sub;
                        count_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    aOpnd_q <= aOpnd_d;
                    bEff_q  <= bEff_d;
                    carry_q <= sliceSum_d[SLICE];
                    if (lastSlice) begin
                        z_q        <= aOpnd_d;
                        cout_q     <= sliceSum_d[SLICE];
                        ovf_q      <= topCarry_d ^ sliceSum_d[SLICE];
                        outValid_q <= 1'b1;
                        count_q    <= '0;
                        state_q    <= DONE;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = outValid_q;
    assign bus.z         = z_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_slice_adder.sv
// Self-checking bench for seq_slice_adder: three instances (32/8, 16/16, 32/4)
// checked against directed values and an arithmetic reference model.
module tb_seq_slice_adder;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    seq_slice_adder_if #(.WIDTH(32)) ifA ();
    seq_slice_adder_if #(.WIDTH(16)) ifB ();
    seq_slice_adder_if #(.WIDTH(32)) ifC ();

    seq_slice_adder #(.WIDTH(32), .SLICE(8))  dutA (.clk(clk), .reset_n(reset_n), .bus(ifA));
    seq_slice_adder #(.WIDTH(16), .SLICE(16)) dutB (.clk(clk), .reset_n(reset_n), .bus(ifB));
    seq_slice_adder #(.WIDTH(32), .SLICE(4))  dutC (.clk(clk), .reset_n(reset_n), .bus(ifC));

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Signed/unsigned arithmetic model over a w-bit word
    function automatic void refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub,
                                     output logic [31:0] z, output logic cout, output logic ovf);
        longint md, half, ua, ub, sa, sb, u, s, c;
        md   = longint'(1) << w;
        half = md >> 1;
        ua   = longint'(a) & (md - 1);
        ub   = longint'(b) & (md - 1);
        c    = cin ? 1 : 0;
        sa   = (ua >= half) ? ua - md : ua;
        sb   = (ub >= half) ? ub - md : ub;
        u    = sub ? (ua - ub - c) : (ua + ub + c);
        s    = sub ? (sa - sb - c) : (sa + sb + c);
        z    = 32'(u & (md - 1));
        cout = sub ? (u >= 0) : (u >= md);
        ovf  = (s >= half) || (s < -half);
    endfunction

    function automatic logic [31:0] pickOperand();
        logic [31:0] corners [4];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    // One full transaction on the 32/8 instance; call at a negedge with the DUT idle
    task automatic opA(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                       output logic [31:0] z, output logic cout, output logic ovf, output int lat);
        ifA.a = a; ifA.b = b; ifA.cin = cin; ifA.sub = sub; ifA.in_valid = 1'b1;
        @(negedge clk);
        ifA.in_valid = 1'b0;
        lat = 0;
        while (ifA.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        z = ifA.z; cout = ifA.cout; ovf = ifA.ovf;
        ifA.out_ready = 1'b1;
        @(negedge clk);
        ifA.out_ready = 1'b0;
    endtask

    // One full transaction on the 16/16 instance
    task automatic opB(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                       output logic [15:0] z, output logic cout, output logic ovf, output int lat);
        ifB.a = a; ifB.b = b; ifB.cin = cin; ifB.sub = sub; ifB.in_valid = 1'b1;
        @(negedge clk);
        ifB.in_valid = 1'b0;
        lat = 0;
        while (ifB.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        z = ifB.z; cout = ifB.cout; ovf = ifB.ovf;
        ifB.out_ready = 1'b1;
        @(negedge clk);
        ifB.out_ready = 1'b0;
    endtask

    // One full transaction on the 32/4 instance
    task automatic opC(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                       output logic [31:0] z, output logic cout, output logic ovf, output int lat);
        ifC.a = a; ifC.b = b; ifC.cin = cin; ifC.sub = sub; ifC.in_valid = 1'b1;
        @(negedge clk);
        ifC.in_valid = 1'b0;
        lat = 0;
        while (ifC.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        z = ifC.z; cout = ifC.cout; ovf = ifC.ovf;
        ifC.out_ready = 1'b1;
        @(negedge clk);
        ifC.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] z; logic co, ov; int lat;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ifA.z !== 32'h0 || ifA.cout !== 1'b0 || ifA.ovf !== 1'b0 || ifA.out_valid !== 1'b0 ||
            ifA.in_ready !== 1'b1 || ifB.in_ready !== 1'b1 || ifC.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_state: z=%h cout=%b ovf=%b ov=%b rdy=%b%b%b required z=0 cout=0 ovf=0 ov=0 rdy=111",
                     ifA.z, ifA.cout, ifA.ovf, ifA.out_valid, ifA.in_ready, ifB.in_ready, ifC.in_ready);
        end
        reset_n = 1'b1;
        @(negedge clk);
        opA(32'hFFFF_FFFF, 32'h0000_0008, 1'b0, 1'b0, z, co, ov, lat);
        checks++;
        if (z !== 32'h7 || co !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_op: z=%h cout=%b required z=00000007 cout=1", z, co);
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (ifA.z !== 32'h0 || ifA.cout !== 1'b0 || ifA.ovf !== 1'b0 || ifA.out_valid !== 1'b0 ||
            ifA.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset: z=%h cout=%b ovf=%b ov=%b rdy=%b required z=0 cout=0 ovf=0 ov=0 rdy=1",
                     ifA.z, ifA.cout, ifA.ovf, ifA.out_valid, ifA.in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [31:0] z; logic co, ov; int lat;
        opA(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, z, co, ov, lat);
        checks++;
        if (z !== 32'h0 || co !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL add_wrap: z=%h cout=%b ovf=%b required z=00000000 cout=1 ovf=0", z, co, ov);
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("[TB] FAIL add_latency: got %0d required 4", lat);
        end
        opA(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, z, co, ov, lat);
        checks++;
        if (z !== 32'h8000_0000 || co !== 1'b0 || ov !== 1'b1) begin
            errors++;
            $display("[TB] FAIL add_cin_ovf: z=%h cout=%b ovf=%b required z=80000000 cout=0 ovf=1", z, co, ov);
        end
    endtask

    task automatic test_sub();
        logic [31:0] z; logic co, ov; int lat;
        opA(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, z, co, ov, lat);
        checks++;
        if (z !== 32'h7FFF_FFFF || co !== 1'b1 || ov !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sub_ovf: z=%h cout=%b ovf=%b required z=7FFFFFFF cout=1 ovf=1", z, co, ov);
        end
        opA(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, z, co, ov, lat);
        checks++;
        if (z !== 32'hFFFF_FFFE || co !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sub_borrow: z=%h cout=%b ovf=%b required z=FFFFFFFE cout=0 ovf=0", z, co, ov);
        end
        opA(32'h0000_0009, 32'h0000_0002, 1'b1, 1'b1, z, co, ov, lat);
        checks++;
        if (z !== 32'h0000_0006 || co !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sub_borrow_in: z=%h cout=%b ovf=%b required z=00000006 cout=1 ovf=0", z, co, ov);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        ifA.a = 32'h1234_5678; ifA.b = 32'h1111_1111; ifA.cin = 1'b0; ifA.sub = 1'b0;
        ifA.in_valid = 1'b1;
        @(negedge clk);
        ifA.a = 32'hDEAD_BEEF; ifA.b = 32'hFFFF_FFFF; ifA.cin = 1'b1;
        lat = 0;
        while (ifA.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 4 || ifA.z !== 32'h2345_6789) begin
            errors++;
            $display("[TB] FAIL bp_result: lat=%0d z=%h required lat=4 z=23456789", lat, ifA.z);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ifA.out_valid !== 1'b1 || ifA.in_ready !== 1'b0 || ifA.z !== 32'h2345_6789 ||
                ifA.cout !== 1'b0 || ifA.ovf !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold: cyc=%0d ov=%b rdy=%b z=%h cout=%b ovf=%b required ov=1 rdy=0 z=23456789 cout=0 ovf=0",
                         i, ifA.out_valid, ifA.in_ready, ifA.z, ifA.cout, ifA.ovf);
            end
        end
        ifA.in_valid = 1'b0;
        ifA.out_ready = 1'b1;
        @(negedge clk);
        ifA.out_ready = 1'b0;
        checks++;
        if (ifA.out_valid !== 1'b0 || ifA.in_ready !== 1'b1 || ifA.z !== 32'h2345_6789) begin
            errors++;
            $display("[TB] FAIL bp_release: ov=%b rdy=%b z=%h required ov=0 rdy=1 z=23456789",
                     ifA.out_valid, ifA.in_ready, ifA.z);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (ifA.out_valid !== 1'b0 || ifA.z !== 32'h2345_6789) begin
            errors++;
            $display("[TB] FAIL bp_no_accept: ov=%b z=%h required ov=0 z=23456789", ifA.out_valid, ifA.z);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] z; logic co, ov; int lat; int seen;
        ifA.a = 32'hAAAA_AAAA; ifA.b = 32'h5555_5555; ifA.cin = 1'b1; ifA.sub = 1'b0;
        ifA.in_valid = 1'b1;
        @(negedge clk);
        ifA.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (ifA.out_valid !== 1'b0 || ifA.z !== 32'h0 || ifA.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrun_reset: ov=%b z=%h rdy=%b required ov=0 z=0 rdy=1",
                     ifA.out_valid, ifA.z, ifA.in_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifA.out_valid !== 1'b0 || ifA.z !== 32'h0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL midrun_discard: bad cycles=%0d required 0", seen);
        end
        opA(32'h1, 32'h1, 1'b0, 1'b0, z, co, ov, lat);
        checks++;
        if (z !== 32'h2 || lat != 4) begin
            errors++;
            $display("[TB] FAIL midrun_recover: z=%h lat=%0d required z=00000002 lat=4", z, lat);
        end
    endtask

    task automatic test_random_slice8();
        logic [31:0] a, b, z, ez; logic cin, sub, co, ov, eco, eov; int lat;
        for (int i = 0; i < 200; i++) begin
            a = pickOperand(); b = pickOperand();
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            refModel(32, a, b, cin, sub, ez, eco, eov);
            opA(a, b, cin, sub, z, co, ov, lat);
            checks++;
            if (z !== ez || co !== eco || ov !== eov || lat != 4) begin
                errors++;
                $display("[TB] FAIL rand8 a=%h b=%h cin=%b sub=%b: z=%h cout=%b ovf=%b lat=%0d required z=%h cout=%b ovf=%b lat=4",
                         a, b, cin, sub, z, co, ov, lat, ez, eco, eov);
            end
        end
    endtask

    task automatic test_wide_slice();
        logic [15:0] z; logic [31:0] a, b, ez; logic cin, sub, co, ov, eco, eov; int lat;
        opB(16'h7FFF, 16'h0001, 1'b0, 1'b0, z, co, ov, lat);
        checks++;
        if (z !== 16'h8000 || ov !== 1'b1 || co !== 1'b0 || lat != 1) begin
            errors++;
            $display("[TB] FAIL w16_ovf: z=%h cout=%b ovf=%b lat=%0d required z=8000 cout=0 ovf=1 lat=1",
                     z, co, ov, lat);
        end
        for (int i = 0; i < 100; i++) begin
            a = {16'h0, 16'($urandom)}; b = {16'h0, 16'($urandom)};
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            refModel(16, a, b, cin, sub, ez, eco, eov);
            opB(a[15:0], b[15:0], cin, sub, z, co, ov, lat);
            checks++;
            if (z !== ez[15:0] || co !== eco || ov !== eov || lat != 1) begin
                errors++;
                $display("[TB] FAIL rand16 a=%h b=%h cin=%b sub=%b: z=%h cout=%b ovf=%b lat=%0d required z=%h cout=%b ovf=%b lat=1",
                         a[15:0], b[15:0], cin, sub, z, co, ov, lat, ez[15:0], eco, eov);
            end
        end
    endtask

    task automatic test_random_slice4();
        logic [31:0] a, b, z, ez; logic cin, sub, co, ov, eco, eov; int lat;
        for (int i = 0; i < 1000; i++) begin
            a = pickOperand(); b = pickOperand();
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            refModel(32, a, b, cin, sub, ez, eco, eov);
            opC(a, b, cin, sub, z, co, ov, lat);
            checks++;
            if (z !== ez || co !== eco || ov !== eov || lat != 8) begin
                errors++;
                $display("[TB] FAIL rand4 a=%h b=%h cin=%b sub=%b: z=%h cout=%b ovf=%b lat=%0d required z=%h cout=%b ovf=%b lat=8",
                         a, b, cin, sub, z, co, ov, lat, ez, eco, eov);
            end
        end
    endtask

    // Test sequence
    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b1;
        ifA.in_valid = 1'b0; ifA.a = '0; ifA.b = '0; ifA.cin = 1'b0; ifA.sub = 1'b0; ifA.out_ready = 1'b0;
        ifB.in_valid = 1'b0; ifB.a = '0; ifB.b = '0; ifB.cin = 1'b0; ifB.sub = 1'b0; ifB.out_ready = 1'b0;
        ifC.in_valid = 1'b0; ifC.a = '0; ifC.b = '0; ifC.cin = 1'b0; ifC.sub = 1'b0; ifC.out_ready = 1'b0;
        #2;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_random_slice8();
        test_wide_slice();
        test_random_slice4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
